ps2_kbd_tx: RTL and testbench

- Keyboard-side PS/2 transmitter, the device end of the PS/2 link. The host-side scancode receiver and scancode-to-ASCII lookup consume its output.
- Accepts one key event per request: scancode, press/release, and extended flag.
- Emits the full PS/2 byte sequence on ps2_clk/ps2_data: optional E0, optional F0, then the code.
- Used as a synthesizable keyboard model for the keyboard path, in simulation and on board.

---
 rtl/ps2_kbd_tx_if.sv | 20 ++
 rtl/ps2_kbd_tx.sv | 169 ++++++++++++++++
 tb/tb_ps2_kbd_tx.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_kbd_tx_if.sv
// Request/handshake bundle between a key-event source and the PS/2 keyboard transmitter.
interface ps2_kbd_tx_if;
    logic       valid;
    logic [7:0] code;
    logic       rel;    // break event: the sequence is prefixed with F0
    logic       ext;    // extended key: the sequence is prefixed with E0
    logic       ready;
    logic       busy;
    logic       done;

    modport master (
        output valid, code, rel, ext,
        input  ready, busy, done
    );

    modport slave (
        input  valid, code, rel, ext,
        output ready, busy, done
    );
endinterface

// File: rtl/ps2_kbd_tx.sv
// Keyboard-side PS/2 transmitter: turns one key event into [E0][F0] code,
// each byte framed as start/8 data LSB-first/odd parity/stop, with idle gaps.
module ps2_kbd_tx #(
    parameter int CLK_DIV = 4,  // system clocks per PS/2 clock half-period, >= 2
    parameter int GAP     = 8   // idle cycles after every byte
) (
    input  logic          clk,
    input  logic          rst,
    ps2_kbd_tx_if.slave   bus,
    output logic          ps2_clk,
    output logic          ps2_data
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             half_q, half_d;     // 0 = clock-high phase, 1 = clock-low phase
    logic [3:0]       bit_q, bit_d;       // frame bit index 0..10
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [1:0]       idx_q, idx_d;       // byte being sent, 0..2
    logic [1:0]       last_q, last_d;     // index of the final byte of the sequence
    logic [23:0]      seq_q, seq_d;       // byte 0 in [7:0], byte 1 in [15:8], byte 2 in [23:16]
    logic             ps2_clk_q, ps2_clk_d;
    logic             ps2_data_q, ps2_data_d;
    logic             done_q, done_d;

    logic [7:0]       cur_byte;
    logic [10:0]      frame;

    // Next-state logic: sequencing through bytes, bits and half-periods, plus
    // the line levels for the coming cycle so the PS/2 pins come straight from flops.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        half_d   = half_q;
        bit_d    = bit_q;
        gap_d    = gap_q;
        idx_d    = idx_q;
        last_d   = last_q;
        seq_d    = seq_q;
        done_d   = 1'b0;
        cur_byte = 8'h00;
        frame    = 11'h7FF;

        case (state_q)
            S_IDLE: begin
                if (bus.valid) begin
                    state_d = S_SEND;
                    div_d   = '0;
                    half_d  = 1'b0;
                    bit_d   = 4'd0;
                    idx_d   = 2'd0;
                    case ({bus.ext, bus.rel})
                        2'b11: begin
                            seq_d  = {bus.code, 8'hF0, 8'hE0};
                            last_d = 2'd2;
                        end
                        2'b10: begin
                            seq_d  = {8'h00, bus.code, 8'hE0};
                            last_d = 2'd1;
                        end
                        2'b01: begin
                            seq_d  = {8'h00, bus.code, 8'hF0};
                            last_d = 2'd1;
                        end
                        default: begin
                            seq_d  = {16'h0000, bus.code};
                            last_d = 2'd0;
                        end
                    endcase
                end
            end

            S_SEND: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!half_q) begin
                        half_d = 1'b1;
                    end else begin
                        half_d = 1'b0;
                        if (bit_q == 4'd10) begin
                            state_d = S_GAP;
                            gap_d   = '0;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (idx_q == last_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_SEND;
                        idx_d   = idx_q + 2'd1;
                        div_d   = '0;
                        half_d  = 1'b0;
                        bit_d   = 4'd0;
                    end
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase

        case (idx_d)
            2'd1:    cur_byte = seq_d[15:8];
            2'd2:    cur_byte = seq_d[23:16];
            default: cur_byte = seq_d[7:0];
        endcase

        // stop, odd parity, data LSB first, start
        frame      = {1'b1, ~^cur_byte, cur_byte, 1'b0};
        ps2_clk_d  = (state_d != S_SEND) || !half_d;
        ps2_data_d = (state_d == S_SEND) ? frame[bit_d] : 1'b1;
    end

    // State registers; reset aborts any frame and forces both lines high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            half_q     <= 1'b0;
            bit_q      <= 4'd0;
            gap_q      <= '0;
            idx_q      <= 2'd0;
            last_q     <= 2'd0;
            seq_q      <= 24'h000000;
            ps2_clk_q  <= 1'b1;
            ps2_data_q <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            half_q     <= half_d;
            bit_q      <= bit_d;
            gap_q      <= gap_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            seq_q      <= seq_d;
            ps2_clk_q  <= ps2_clk_d;
            ps2_data_q <= ps2_data_d;
            done_q     <= done_d;
        end
    end

    assign bus.ready = (state_q == S_IDLE);
    assign bus.busy  = (state_q != S_IDLE);
    assign bus.done  = done_q;
    assign ps2_clk   = ps2_clk_q;
    assign ps2_data  = ps2_data_q;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Self-checking bench for ps2_kbd_tx: cycle-exact waveform model plus a
// host-side falling-edge decoder, over directed and random key events.
module tb_ps2_kbd_tx;

    localparam int CLK_DIV  = 4;
    localparam int GAP_C    = 8;
    localparam int BIT_CYC  = 2 * CLK_DIV;
    localparam int SEND_CYC = 22 * CLK_DIV;
    localparam int BYTE_CYC = SEND_CYC + GAP_C;

    logic clk = 1'b0;
    logic rst;
    logic ps2_clk;
    logic ps2_data;
    int   total = 0;
    int   bad   = 0;

    ps2_kbd_tx_if bus ();

    ps2_kbd_tx #(.CLK_DIV(CLK_DIV), .GAP(GAP_C)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data)
    );

    always #5 clk = ~clk;

    // Expected level of frame bit idx for byte b (start, data LSB first, odd parity, stop)
    function automatic logic ref_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (idx == 9) return ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_event(input logic [7:0] c, input logic r, input logic e);
        bus.valid = 1'b1;
        bus.code  = c;
        bus.rel   = r;
        bus.ext   = e;
        step();
        bus.valid = 1'b0;
    endtask

    // Follows one accepted event from the first cycle after acceptance to the done cycle.
    // inject_s: pulse a stray request at that cycle; abort_s: assert reset at that cycle;
    // chain: hold a new request during the done cycle.
    task automatic run_seq(input string name, input logic [7:0] c, input logic r, input logic e,
                           input int inject_s, input int abort_s, input bit chain,
                           input logic [7:0] chain_code);
        logic [7:0]  exp_q[$];
        logic [7:0]  dec_q[$];
        logic [4:0]  exp_v;
        logic [4:0]  act_v;
        logic [10:0] sh;
        logic        prev_clk;
        int          n, len, t, k, rr, bi, nbits;
        bit          fmt_ok;
        bit          aborted;

        exp_q = {};
        dec_q = {};
        if (e) exp_q.push_back(8'hE0);
        if (r) exp_q.push_back(8'hF0);
        exp_q.push_back(c);
        n        = exp_q.size();
        len      = n * BYTE_CYC + 1;
        prev_clk = 1'b1;
        nbits    = 0;
        fmt_ok   = 1'b1;
        aborted  = 1'b0;
        sh       = '0;

        for (int s = 1; s <= len; s++) begin
            t = s - 1;
            // order: {ps2_clk, ps2_data, ready, busy, done}
            if (t < n * BYTE_CYC) begin
                k  = t / BYTE_CYC;
                rr = t % BYTE_CYC;
                if (rr < SEND_CYC) begin
                    bi    = rr / BIT_CYC;
                    exp_v = {((rr % BIT_CYC) < CLK_DIV) ? 1'b1 : 1'b0,
                             ref_bit(exp_q[k], bi), 3'b010};
                end else begin
                    exp_v = {2'b11, 3'b010};
                end
            end else begin
                exp_v = {2'b11, 3'b101};
            end
            act_v = {ps2_clk, ps2_data, bus.ready, bus.busy, bus.done};
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL %s cycle %0d: {clk,data,ready,busy,done} got %b want %b",
                         name, s, act_v, exp_v);
            end

            // host-side receiver: sample data on each falling PS/2 clock edge
            if (prev_clk === 1'b1 && ps2_clk === 1'b0) begin
                sh[nbits] = ps2_data;
                nbits++;
                if (nbits == 11) begin
                    if (sh[0] !== 1'b0 || sh[10] !== 1'b1 || (^sh[9:1]) !== 1'b1) fmt_ok = 1'b0;
                    dec_q.push_back(sh[8:1]);
                    nbits = 0;
                end
            end
            prev_clk = ps2_clk;

            if (s == abort_s) begin
                rst     = 1'b1;
                aborted = 1'b1;
                break;
            end
            if (s == inject_s) begin
                bus.valid = 1'b1;
                bus.code  = 8'h23;
            end
            if (s == inject_s + 1) bus.valid = 1'b0;
            if (s == len && chain) begin
                bus.valid = 1'b1;
                bus.code  = chain_code;
                bus.rel   = 1'b0;
                bus.ext   = 1'b0;
            end
            step();
            if (s == len && chain) bus.valid = 1'b0;
        end

        if (aborted) begin
            step();
            rst = 1'b0;
        end else begin
            total++;
            if (dec_q.size() != n) begin
                bad++;
                $display("FAIL %s decoded_count: got %0d want %0d", name, dec_q.size(), n);
            end
            for (int i = 0; i < n && i < dec_q.size(); i++) begin
                total++;
                if (dec_q[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL %s decoded_byte[%0d]: got %02h want %02h",
                             name, i, dec_q[i], exp_q[i]);
                end
            end
            total++;
            if (fmt_ok !== 1'b1) begin
                bad++;
                $display("FAIL %s frame_format: got %0b want 1", name, fmt_ok);
            end
            $display("seq %s code=%02h rel=%0b ext=%0b bytes=%0d decoded=%0d",
                     name, c, r, e, n, dec_q.size());
        end
    endtask

    task automatic test_reset();
        logic [4:0] act_v;
        rst       = 1'b1;
        bus.valid = 1'b1;
        bus.code  = 8'($urandom_range(0, 255));
        bus.rel   = 1'b0;
        bus.ext   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            act_v = {ps2_clk, ps2_data, bus.ready, bus.busy, bus.done};
            total++;
            if (act_v !== 5'b11100) begin
                bad++;
                $display("FAIL reset_hold cycle %0d: got %b want 11100", i, act_v);
            end
        end
        rst       = 1'b0;
        bus.valid = 1'b0;
        for (int i = 0; i < 2 * BYTE_CYC; i++) begin
            step();
            act_v = {ps2_clk, ps2_data, bus.ready, bus.busy, bus.done};
            total++;
            if (act_v !== 5'b11100) begin
                bad++;
                $display("FAIL reset_idle cycle %0d: got %b want 11100", i, act_v);
            end
        end
        $display("reset: idle checked for %0d cycles", 2 * BYTE_CYC);
    endtask

    task automatic test_make();
        start_event(8'h1C, 1'b0, 1'b0);
        run_seq("make_1C", 8'h1C, 1'b0, 1'b0, -1, -1, 1'b0, 8'h00);
    endtask

    task automatic test_break();
        start_event(8'h1C, 1'b1, 1'b0);
        run_seq("break_1C", 8'h1C, 1'b1, 1'b0, -1, -1, 1'b0, 8'h00);
    endtask

    task automatic test_ext_break();
        start_event(8'h75, 1'b1, 1'b1);
        run_seq("ext_break_75", 8'h75, 1'b1, 1'b1, -1, -1, 1'b0, 8'h00);
    endtask

    task automatic test_back_to_back();
        start_event(8'h1C, 1'b0, 1'b0);
        run_seq("busy_reject_1C", 8'h1C, 1'b0, 1'b0, 40, -1, 1'b1, 8'h23);
        run_seq("b2b_23", 8'h23, 1'b0, 1'b0, -1, -1, 1'b0, 8'h00);
    endtask

    task automatic test_mid_reset();
        logic [4:0] act_v;
        start_event(8'h1C, 1'b0, 1'b0);
        // data bit 4 is frame bit 5: cycles 41..48 after acceptance
        run_seq("abort_1C", 8'h1C, 1'b0, 1'b0, -1, 43, 1'b0, 8'h00);
        act_v = {ps2_clk, ps2_data, bus.ready, bus.busy, bus.done};
        total++;
        if (act_v !== 5'b11100) begin
            bad++;
            $display("FAIL mid_reset_after: got %b want 11100", act_v);
        end
        for (int i = 0; i < BYTE_CYC; i++) begin
            step();
            act_v = {ps2_clk, ps2_data, bus.ready, bus.busy, bus.done};
            total++;
            if (act_v !== 5'b11100) begin
                bad++;
                $display("FAIL mid_reset_idle cycle %0d: got %b want 11100", i, act_v);
            end
        end
        $display("mid_reset: aborted at cycle 43, idle afterwards");
        start_event(8'h1C, 1'b0, 1'b0);
        run_seq("after_abort_1C", 8'h1C, 1'b0, 1'b0, -1, -1, 1'b0, 8'h00);
    endtask

    task automatic test_random();
        logic [7:0] c;
        logic       r;
        logic       e;
        int         idle;
        for (int i = 0; i < 10; i++) begin
            c    = (i == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            r    = 1'($urandom_range(0, 1));
            e    = 1'($urandom_range(0, 1));
            idle = $urandom_range(0, 3);
            for (int j = 0; j < idle; j++) step();
            start_event(c, r, e);
            run_seq("random", c, r, e, -1, -1, 1'b0, 8'h00);
        end
    endtask

    initial begin
        rst       = 1'b0;
        bus.valid = 1'b0;
        bus.code  = 8'h00;
        bus.rel   = 1'b0;
        bus.ext   = 1'b0;
        #1;
        test_reset();
        test_make();
        test_break();
        test_ext_break();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
